// File: rtl/des_round_sequencer.sv
// des_round_sequencer: control FSM for an iterative single-round DES datapath.
// Each accepted job produces a one-cycle load, 16 round strobes carrying the
// key-rotation schedule, a one-cycle final strobe, and then holds out_valid
// until the consumer takes it.
module des_round_sequencer #(
  parameter int NUM_ROUNDS   = 16,  // schedule table only covers 16 rounds
  parameter int ROUND_CYCLES = 1    // 1..8 clocks per round
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_decrypt,
  input  logic       abort,
  output logic       dp_load,
  output logic       dp_round_en,
  output logic [3:0] round_idx,
  output logic [1:0] shift_amt,
  output logic       shift_right,
  output logic       dp_final,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_DONE
  } state_t;

  state_t     r_state, w_next;
  logic [3:0] r_round;
  logic [2:0] r_wait;
  logic       r_decrypt;
  logic       w_win_end;
  logic       w_last;
  logic [1:0] w_shift_enc;

  assign w_win_end = (r_wait == 3'(ROUND_CYCLES - 1));
  assign w_last    = (r_round == 4'(NUM_ROUNDS - 1));

  // Encrypt rotation table: single shifts at rounds 0, 1, 8, 15, double otherwise.
  // Decrypt reuses it except round 0, where PC-1 output already equals K16.
  assign w_shift_enc = ((r_round == 4'd0) || (r_round == 4'd1) ||
                        (r_round == 4'd8) || (r_round == 4'd15)) ? 2'd1 : 2'd2;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort beats every other transition except in IDLE,
  // where it is ignored and an accept still happens
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_LOAD;
      S_LOAD:  w_next = abort ? S_IDLE : S_ROUND;
      S_ROUND: begin
        if (abort)                 w_next = S_IDLE;
        else if (w_win_end && w_last) w_next = S_FINAL;
      end
      S_FINAL: w_next = abort ? S_IDLE : S_DONE;
      S_DONE:  if (abort || out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Mode latch plus round/wait counters; counters idle at 0 outside ROUND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round   <= 4'd0;
      r_wait    <= 3'd0;
      r_decrypt <= 1'b0;
    end else begin
      if (r_state == S_IDLE && in_valid) r_decrypt <= in_decrypt;
      if (r_state != S_ROUND) begin
        r_round <= 4'd0;
        r_wait  <= 3'd0;
      end else if (w_win_end) begin
        r_wait <= 3'd0;
        if (!w_last) r_round <= r_round + 4'd1;
      end else begin
        r_wait <= r_wait + 3'd1;
      end
    end
  end

  // Output decode; in_ready is held low while reset is asserted
  always_comb begin
    in_ready    = (r_state == S_IDLE) && !rst;
    busy        = (r_state != S_IDLE);
    dp_load     = (r_state == S_LOAD);
    dp_final    = (r_state == S_FINAL);
    out_valid   = (r_state == S_DONE);
    dp_round_en = 1'b0;
    round_idx   = 4'd0;
    shift_amt   = 2'd0;
    shift_right = 1'b0;
    if (r_state == S_ROUND) begin
      dp_round_en = (r_wait == 3'd0);
      round_idx   = r_round;
      shift_right = r_decrypt;
      shift_amt   = (r_decrypt && r_round == 4'd0) ? 2'd0 : w_shift_enc;
    end
  end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: two instances (ROUND_CYCLES 1 and 3) share
// stimulus; a timeline model derived from cycles-since-accept predicts every
// output every cycle, and literal expectations pin schedule and latency.
module tb_des_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_decrypt = 1'b0, abort = 1'b0, out_ready = 1'b0;

  always #5 clk = ~clk;

  logic [1:0]      w_rdy, w_load, w_rnd, w_dir, w_fin, w_ov, w_busy;
  logic [1:0][3:0] w_idx;
  logic [1:0][1:0] w_sh;

  des_round_sequencer #(.NUM_ROUNDS(16), .ROUND_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_rdy[0]),
    .in_decrypt(in_decrypt), .abort(abort), .dp_load(w_load[0]),
    .dp_round_en(w_rnd[0]), .round_idx(w_idx[0]), .shift_amt(w_sh[0]),
    .shift_right(w_dir[0]), .dp_final(w_fin[0]), .out_valid(w_ov[0]),
    .out_ready(out_ready), .busy(w_busy[0]));

  des_round_sequencer #(.NUM_ROUNDS(16), .ROUND_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_rdy[1]),
    .in_decrypt(in_decrypt), .abort(abort), .dp_load(w_load[1]),
    .dp_round_en(w_rnd[1]), .round_idx(w_idx[1]), .shift_amt(w_sh[1]),
    .shift_right(w_dir[1]), .dp_final(w_fin[1]), .out_valid(w_ov[1]),
    .out_ready(out_ready), .busy(w_busy[1]));

  int errors = 0, checks = 0, cyc = 0;

  // model state: job active, cycles since accept, latched mode
  bit          m_act [2];
  int          m_k   [2];
  bit          m_dec [2];
  // observations of the DUTs for literal checks
  int          t_acc [2];
  int          t_ov  [2];
  int          n_str [2];
  int          rot   [2];
  logic [31:0] seq   [2];
  bit          prev_ov [2];

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  function automatic logic [12:0] obs(int i);
    return {w_load[i], w_rnd[i], w_idx[i], w_sh[i], w_dir[i], w_fin[i],
            w_ov[i], w_rdy[i], w_busy[i]};
  endfunction

  // Per-cycle compare against the timeline model, then advance the model
  always @(negedge clk) begin
    bit el, er, ed, ef, eo, ey, eb;
    int rc, len, j, ei, es;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      rc = (i == 0) ? 1 : 3;
      len = 16 * rc;
      {el, er, ed, ef, eo, ey, eb} = '0;
      ei = 0; es = 0;
      if (!rst) begin
        if (!m_act[i]) ey = 1'b1;
        else begin
          eb = 1'b1;
          if (m_k[i] == 1) el = 1'b1;
          else if (m_k[i] <= 1 + len) begin
            j  = m_k[i] - 2;
            ei = j / rc;
            er = (j % rc) == 0;
            ed = m_dec[i];
            es = (ei == 0 || ei == 1 || ei == 8 || ei == 15) ? 1 : 2;
            if (m_dec[i] && ei == 0) es = 0;
          end
          else if (m_k[i] == 2 + len) ef = 1'b1;
          else eo = 1'b1;
        end
      end
      chk("outputs{ld,rnd,idx,sh,dir,fin,ov,rdy,busy}", i, 32'(obs(i)),
          32'({el, er, 4'(ei), 2'(es), ed, ef, eo, ey, eb}));

      if (w_rnd[i] === 1'b1) begin
        n_str[i]++;
        seq[i] = seq[i] | (32'(w_sh[i]) << (2 * w_idx[i]));
        rot[i] += int'(w_sh[i]);
      end
      if (w_ov[i] === 1'b1 && !prev_ov[i]) t_ov[i] = cyc - t_acc[i];
      prev_ov[i] = (w_ov[i] === 1'b1);

      if (rst) m_act[i] = 1'b0;
      else if (!m_act[i]) begin
        if (in_valid) begin
          m_act[i] = 1'b1; m_k[i] = 1; m_dec[i] = in_decrypt;
          t_acc[i] = cyc; t_ov[i] = -1; n_str[i] = 0; rot[i] = 0; seq[i] = '0;
        end
      end
      else if (abort) m_act[i] = 1'b0;
      else if (m_k[i] >= 3 + len && out_ready) m_act[i] = 1'b0;
      else m_k[i]++;
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_job(logic [31:0] sched, int total_rot);
    for (int i = 0; i < 2; i++) begin
      chk("schedule", i, seq[i], sched);
      chk("rotation", i, 32'(rot[i]), 32'(total_rot));
      chk("strobes", i, 32'(n_str[i]), 32'd16);
      chk("latency", i, 32'(t_ov[i]), (i == 0) ? 32'd19 : 32'd51);
    end
  endtask

  initial begin
    bit found;
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);

    // encrypt job; in_decrypt toggled mid-job must not matter
    out_ready = 1'b1; in_decrypt = 1'b0; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(5); in_decrypt = 1'b1;
    step(60); in_decrypt = 1'b0;
    chk_job(32'h6AA9AAA5, 28);

    // decrypt job under backpressure, in_valid held high throughout
    out_ready = 1'b0; in_decrypt = 1'b1; in_valid = 1'b1;
    step(1);
    in_decrypt = 1'b0;
    step(64);
    chk_job(32'h6AA9AAA4, 27);
    out_ready = 1'b1;
    step(2);               // handshake, then back-to-back accept
    in_valid = 1'b0;
    step(60);
    chk_job(32'h6AA9AAA5, 28);

    // abort once dut1 strobes round 7
    in_valid = 1'b1; step(1); in_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (w_rnd[0] && w_idx[0] == 4'd7) found = 1'b1;
      else step(1);
    end
    chk("reach_round7", 0, 32'(found), 32'd1);
    abort = 1'b1; step(1); abort = 1'b0;
    step(40);
    chk("abort_strobes", 0, 32'(n_str[0]), 32'd8);
    chk("abort_no_result", 0, 32'(t_ov[0]), 32'hFFFF_FFFF);

    // abort together with out_ready in DONE drops the result
    out_ready = 1'b0; in_valid = 1'b1; step(1); in_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (w_ov[0]) found = 1'b1;
      else step(1);
    end
    chk("reach_done", 0, 32'(found), 32'd1);
    abort = 1'b1; out_ready = 1'b1; step(1); abort = 1'b0;
    chk("done_abort_ov", 0, 32'(w_ov[0]), 32'd0);
    chk("done_abort_rdy", 0, 32'(w_rdy[0]), 32'd1);

    // abort in IDLE is ignored and the accept still happens
    step(2);
    abort = 1'b1; in_valid = 1'b1; step(1); abort = 1'b0; in_valid = 1'b0;
    chk("idle_abort_load", 0, 32'(w_load[0]), 32'd1);
    chk("idle_abort_load", 1, 32'(w_load[1]), 32'd1);
    step(60);
    chk_job(32'h6AA9AAA5, 28);

    // asynchronous reset mid-ROUND, then a fresh job
    in_valid = 1'b1; step(1); in_valid = 1'b0;
    step(8);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", 0, 32'(obs(0)), 32'd0);
    chk("async_rst_outputs", 1, 32'(obs(1)), 32'd0);
    step(2);
    rst = 1'b0;
    step(1);
    in_decrypt = 1'b1; in_valid = 1'b1; step(1); in_valid = 1'b0;
    step(60);
    chk_job(32'h6AA9AAA4, 27);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_round_sequencer.md
Name: des_round_sequencer

Overview:
Control FSM for an iterative single-round DES datapath. It accepts one 64-bit block job per handshake and latches the encrypt/decrypt mode for that job. It then strobes the datapath through load, 16 Feistel rounds with the correct per-round key-rotation schedule, and final permutation, and holds the result valid until the consumer accepts it. It sits between the host-side job interface and the round datapath: initial permutation, PC-1/PC-2, E-expansion, S-box lookup, swap.

Parameters:
NUM_ROUNDS, 16, number of Feistel rounds; the schedule table is defined for 16 only, and any other value is illegal.
ROUND_CYCLES, 1, clock cycles per round (1..8); a round strobe is issued once every ROUND_CYCLES cycles.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous and active-high
in_valid  input  1  job request
in_ready  output  1  sequencer can accept a job
in_decrypt  input  1  mode for the job (0 = encrypt, 1 = decrypt), sampled at accept
abort  input  1  synchronous cancel of the current job
dp_load  output  1  one-cycle strobe: datapath loads IP(block) into L/R and PC-1(key) into C/D
dp_round_en  output  1  one-cycle strobe: datapath performs one round
round_idx  output  4  index of the round being strobed (0..15)
shift_amt  output  2  C/D rotation applied before this round's PC-2
shift_right  output  1  rotation direction (0 = left for encrypt, 1 = right for decrypt)
dp_final  output  1  one-cycle strobe: datapath applies R16/L16 swap and FP into the output register
out_valid  output  1  result register holds a finished block
out_ready  input  1  consumer accepts the result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, round counter=0, wait counter=0, mode=0. All strobes 0, round_idx=0, shift_amt=0, shift_right=0, out_valid=0, busy=0, in_ready=1 once rst is released. A reset mid-job discards the job with no out_valid.
- States and transitions:
  - IDLE: in_ready=1. Accept = in_valid & in_ready; on accept, latch the mode and go to LOAD.
  - LOAD: dp_load=1 for exactly one cycle, then go to ROUND with the counter at 0.
  - ROUND: dp_round_en=1 on the first cycle of each ROUND_CYCLES window, 0 on the other cycles of the window. At the end of the window the counter increments. After round_idx=15 finishes, go to FINAL.
  - FINAL: dp_final=1 for one cycle, then go to DONE.
  - DONE: out_valid=1, held until out_ready=1. On the out_valid & out_ready cycle, go to IDLE.
- in_ready is 0 in every state except IDLE; there is no same-cycle accept in DONE. A new job can be accepted one cycle after the DONE handshake.
- Latency, ROUND_CYCLES=1, accept at cycle T:
  - dp_load at T+1
  - round strobes at T+2..T+17 (idx 0..15)
  - dp_final at T+18
  - out_valid first high at T+19
  - General form: out_valid first high at T+3+16*ROUND_CYCLES.
- round_idx, shift_amt and shift_right are valid whenever dp_round_en=1 and are held stable for the whole ROUND_CYCLES window. Outside ROUND they are 0.
- Shift schedule, encrypt (shift_right=0): shift_amt=1 at idx 0, 1, 8, 15; 2 otherwise. Total rotation is 28.
- Shift schedule, decrypt (shift_right=1): shift_amt=0 at idx 0, because PC-1 output already equals K16. shift_amt=1 at idx 1, 8, 15; 2 otherwise. Total rotation is 27 right.
- Mode is latched at accept; changes on in_decrypt during a job have no effect.
- abort=1 in LOAD, ROUND or FINAL: next state IDLE, no further strobes, no out_valid.
- abort in DONE: out_valid drops next cycle, state IDLE, result is discarded.
- abort in IDLE: ignored, and accept still happens if in_valid=1 on the same cycle.
- abort has priority over every other transition in the same cycle, including out_ready in DONE.
- Counters wrap never: round counter saturates at the 15 to FINAL transition; wait counter is reset at each round boundary.

Test Plan:
- Encrypt, ROUND_CYCLES=1: accept at T -> dp_load at T+1; 16 dp_round_en pulses at T+2..T+17 with shift_amt 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 and shift_right=0; dp_final at T+18; out_valid at T+19. With the datapath attached, key 133457799BBCDFF1 and block 0123456789ABCDEF give 85E813540F0AB405.
- Decrypt of 85E813540F0AB405 with the same key: shift_amt 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with shift_right=1 -> output 0123456789ABCDEF.
- ROUND_CYCLES=3: strobes every 3rd cycle, round_idx held for 3 cycles, out_valid at T+51. in_decrypt toggled mid-job -> schedule unchanged.
- Backpressure: out_ready=0 for 10 cycles -> out_valid stays 1, in_ready stays 0, no strobes. in_valid held high -> next accept exactly 1 cycle after the handshake.
- abort at round_idx=7 -> no further dp_round_en, no dp_final, no out_valid, in_ready=1 next cycle. abort with out_ready=1 in DONE -> result dropped.
- rst asserted asynchronously mid-ROUND -> all outputs 0 immediately, in_ready=1 after release, and a fresh job completes with correct latency.
